// File: rtl/qmac_pkg.sv
// rtl/qmac_pkg.sv - shared types and helpers for the quantization MAC input path
//
// Purpose : FSM state encoding for the operand arbiter, requester-id width
//           helper and the bit-offset helper for packed per-requester buses.
// Ports   : none (package).

package qmac_pkg;

    // Arbiter FSM: one arbitration cycle, then beats of the granted burst.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Width of a requester id. A single-bit id is kept as the floor so that
    // NUM_REQ = 2 (the common activation/weight pairing) still has a usable bus.
    function automatic int id_w(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

    // Low bit of requester idx inside a bus packed as idx*w +: w.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin first-valid search
//
// Purpose : Starting one past the last winner, return the first requester
//           whose valid bit is set, wrapping modulo NUM_REQ.
// Ports   : valid_i  - per-requester request bits
//           ptr_i    - last winner; the search starts at ptr_i+1
//           found_o  - at least one request is present
//           idx_o    - id of the chosen requester (0 when none found)

module rr_pick
    import qmac_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic               found_o,
    output logic [ID_W-1:0]    idx_o
);

    always_comb begin
        int cand;
        logic hit;
        cand    = 0;
        hit     = 1'b0;
        found_o = 1'b0;
        idx_o   = '0;
        // Offset k = NUM_REQ lands back on ptr_i itself, so the last winner
        // is considered only after every other requester.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr_i) + k) % NUM_REQ;
            if (!hit && valid_i[cand]) begin
                hit   = 1'b1;
                idx_o = ID_W'(cand);
            end
        end
        found_o = hit;
    end

endmodule

// File: rtl/input_arbiter.sv
// rtl/input_arbiter.sv - round-robin burst arbiter feeding one input_first converter
//
// Purpose : Shares a single converter between NUM_REQ operand sources. A
//           requester is granted for a burst of up to MAX_BURST beats; each
//           accepted beat drives the converter and fills a one-deep tagged
//           result slot that the downstream MAC drains with dn_ready.
// Ports   : clk, rst            - clock, synchronous active-low reset
//           req_valid/req_ready - per-requester beat handshake
//           req_data/req_n      - packed per-requester data and n
//           req_type/req_last   - per-requester type_sel and burst end
//           cv_en/cv_indata     - converter capture enable and data (combinational)
//           cv_type_sel/cv_n    - converter fields held from the last accept
//           res_valid/res_id    - result present and its source id
//           dn_ready            - downstream consumes the result this cycle

module input_arbiter
    import qmac_pkg::*;
#(
    parameter int width_in     = 16,
    parameter int width_in_exp = 5,
    parameter int NUM_REQ      = 2,
    parameter int MAX_BURST    = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*width_in-1:0]     req_data,
    input  logic [NUM_REQ-1:0]              req_type,
    input  logic [NUM_REQ*width_in_exp-1:0] req_n,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            cv_en,
    output logic [width_in-1:0]             cv_indata,
    output logic                            cv_type_sel,
    output logic [width_in_exp-1:0]         cv_n,
    output logic                            res_valid,
    output logic [id_w(NUM_REQ)-1:0]        res_id,
    input  logic                            dn_ready
);

    localparam int ID_W  = id_w(NUM_REQ);
    localparam int CNT_W = (MAX_BURST <= 2) ? 1 : $clog2(MAX_BURST);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]  PTR_RST   = ID_W'(NUM_REQ - 1);

    arb_state_e              state_q;
    logic [ID_W-1:0]         ptr_q;
    logic [ID_W-1:0]         grant_q;
    logic [CNT_W-1:0]        beat_cnt_q;
    logic [CNT_W-1:0]        beat_cnt_d;
    logic                    cv_type_sel_q;
    logic [width_in_exp-1:0] cv_n_q;
    logic                    res_valid_q;
    logic [ID_W-1:0]         res_id_q;

    logic                    pick_found;
    logic [ID_W-1:0]         pick_idx;

    logic                    in_burst;
    logic                    slot_free;
    logic                    grant_valid;
    logic                    grant_last;
    logic                    grant_type;
    logic [width_in-1:0]     grant_data;
    logic [width_in_exp-1:0] grant_n;
    logic                    accept;
    logic                    burst_done;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Granted requester's view of the packed input buses.
    assign grant_valid = req_valid[grant_q];
    assign grant_last  = req_last[grant_q];
    assign grant_type  = req_type[grant_q];
    assign grant_data  = req_data[slice_lo(int'(grant_q), width_in) +: width_in];
    assign grant_n     = req_n[slice_lo(int'(grant_q), width_in_exp) +: width_in_exp];

    assign in_burst   = (state_q == ST_BURST);
    // The slot can take a new beat when it is empty or being drained now.
    assign slot_free  = !res_valid_q || dn_ready;
    assign accept     = in_burst && grant_valid && slot_free;
    assign burst_done = grant_last || (beat_cnt_q == LAST_BEAT);
    assign beat_cnt_d = beat_cnt_q + CNT_W'(1);

    always_comb begin
        req_ready = '0;
        if (in_burst) begin
            req_ready[grant_q] = slot_free;
        end
    end

    assign cv_en       = accept;
    assign cv_indata   = grant_data;
    assign cv_type_sel = cv_type_sel_q;
    assign cv_n        = cv_n_q;
    assign res_valid   = res_valid_q;
    assign res_id      = res_id_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= PTR_RST;
            grant_q       <= '0;
            beat_cnt_q    <= '0;
            cv_type_sel_q <= 1'b0;
            cv_n_q        <= '0;
            res_valid_q   <= 1'b0;
            res_id_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_q    <= pick_idx;
                        beat_cnt_q <= '0;
                        state_q    <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    // A stalled or silent grantee keeps the grant; only an
                    // accepted final beat hands arbitration back.
                    if (accept) begin
                        if (burst_done) begin
                            state_q <= ST_IDLE;
                            ptr_q   <= grant_q;
                        end else begin
                            beat_cnt_q <= beat_cnt_d;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // type_sel/n feed the converter's registered fields combinationally,
            // so they may only move on the edge that captures a new beat.
            if (accept) begin
                cv_type_sel_q <= grant_type;
                cv_n_q        <= grant_n;
                res_valid_q   <= 1'b1;
                res_id_q      <= grant_q;
            end else if (dn_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

endmodule
